// File: rtl/rose_delay_checker.sv
// Temporal checker: every sampled rise of a must be followed by b==1 exactly DELAY edges later.
// Define ROSE_CHK_CNT_EN to build the saturating pass/fail verdict counters; otherwise they are tied to 0.
module rose_delay_checker #(
   parameter int DELAY = 10,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             a,
   input  logic             b,
   output logic             pass,
   output logic             fail,
   output logic             busy,
   output logic             err_sticky,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt
);

   logic             a_q, a_d;
   logic [DELAY-1:0] pend_q, pend_d;
   logic             pass_q, pass_d;
   logic             fail_q, fail_d;
   logic             err_q, err_d;
   logic             rise;
   logic             verdict;

   assign rise    = a & ~a_q;
   assign verdict = pend_q[DELAY-1];

   // pend_q[k] holds an attempt that was launched k+1 edges ago
   always_comb begin
      a_d       = a;
      pend_d    = '0;
      pend_d[0] = rise & en;
      for (int k = 1; k < DELAY; k++) begin
         pend_d[k] = pend_q[k-1];
      end
      pass_d = verdict & b;
      fail_d = verdict & ~b;
      err_d  = err_q | (verdict & ~b);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q    <= 1'b0;
         pend_q <= '0;
         pass_q <= 1'b0;
         fail_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         a_q    <= a_d;
         pend_q <= pend_d;
         pass_q <= pass_d;
         fail_q <= fail_d;
         err_q  <= err_d;
      end
   end

   assign pass       = pass_q;
   assign fail       = fail_q;
   assign busy       = |pend_q;
   assign err_sticky = err_q;

`ifdef ROSE_CHK_CNT_EN
   logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
   logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;

   // Counters advance on the same edge that registers the verdict and hold at all-ones
   always_comb begin
      pass_cnt_d = pass_cnt_q;
      fail_cnt_d = fail_cnt_q;
      if (verdict && b && !(&pass_cnt_q)) begin
         pass_cnt_d = pass_cnt_q + CNT_W'(1);
      end
      if (verdict && !b && !(&fail_cnt_q)) begin
         fail_cnt_d = fail_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pass_cnt_q <= '0;
         fail_cnt_q <= '0;
      end else begin
         pass_cnt_q <= pass_cnt_d;
         fail_cnt_q <= fail_cnt_d;
      end
   end

   assign pass_cnt = pass_cnt_q;
   assign fail_cnt = fail_cnt_q;
`else
   assign pass_cnt = '0;
   assign fail_cnt = '0;
`endif

endmodule

// File: tb/tb_rose_delay_checker.sv
// Directed self-checking bench for rose_delay_checker with DELAY=10, CNT_W=2.
module tb_rose_delay_checker;

   localparam int DELAY = 10;
   localparam int CNT_W = 2;

   logic             clk;
   logic             rst;
   logic             en;
   logic             a;
   logic             b;
   logic             pass;
   logic             fail;
   logic             busy;
   logic             err_sticky;
   logic [CNT_W-1:0] pass_cnt;
   logic [CNT_W-1:0] fail_cnt;

   int checks = 0;
   int errors = 0;

   rose_delay_checker #(.DELAY(DELAY), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .a         (a),
      .b         (b),
      .pass      (pass),
      .fail      (fail),
      .busy      (busy),
      .err_sticky(err_sticky),
      .pass_cnt  (pass_cnt),
      .fail_cnt  (fail_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drive a/b for the next edge, then sample 1 time unit after it
   task automatic applyStimulus(input logic a_v, input logic b_v);
      a = a_v;
      b = b_v;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1;
      en  = 1'b1;
      a   = 1'b0;
      b   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("rst_pass", pass, 0);
      checkOutput("rst_fail", fail, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_err", err_sticky, 0);
      checkOutput("rst_pcnt", pass_cnt, 0);
      checkOutput("rst_fcnt", fail_cnt, 0);
      rst = 1'b0;
   endtask

   function automatic int satCnt(input int e);
      int n;
      n = (e >= 11) ? ((e - 11) / 2 + 1) : 0;
      if (n > 5) n = 5;
      return (n > 3) ? 3 : n;
   endfunction

   initial begin
      $display("[TB] start");

      // Test 1: single rise, b high at maturity
      doReset();
      for (int e = 1; e <= 12; e++) begin
         applyStimulus(e == 1, e == 11);
         checkOutput("t1_pass", pass, (e == 11) ? 1 : 0);
         checkOutput("t1_fail", fail, 0);
         checkOutput("t1_busy", busy, (e <= 10) ? 1 : 0);
      end
      checkOutput("t1_err", err_sticky, 0);

      // Test 2: b low exactly at maturity, high on the neighbouring edges
      doReset();
      for (int e = 1; e <= 20; e++) begin
         applyStimulus(e == 1, (e == 10) || (e == 12));
         checkOutput("t2_pass", pass, 0);
         checkOutput("t2_fail", fail, (e == 11) ? 1 : 0);
         checkOutput("t2_err", err_sticky, (e >= 11) ? 1 : 0);
      end

      // Test 3: a held high from the first edge after reset
      doReset();
      for (int e = 1; e <= 30; e++) begin
         applyStimulus(1'b1, 1'b1);
         checkOutput("t3_pass", pass, (e == 11) ? 1 : 0);
         checkOutput("t3_fail", fail, 0);
      end

      // Test 4: two overlapping attempts with different verdicts
      doReset();
      for (int e = 1; e <= 15; e++) begin
         applyStimulus((e == 1) || (e == 3), e == 11);
         checkOutput("t4_pass", pass, (e == 11) ? 1 : 0);
         checkOutput("t4_fail", fail, (e == 13) ? 1 : 0);
         checkOutput("t4_busy", busy, (e <= 12) ? 1 : 0);
      end

      // Test 5: async reset mid-flight discards the attempt
      doReset();
      for (int e = 1; e <= 5; e++) begin
         applyStimulus(e == 1, 1'b0);
         checkOutput("t5_busy_pre", busy, 1);
      end
      rst = 1'b1;
      #2;
      checkOutput("t5_busy_rst", busy, 0);
      rst = 1'b0;
      for (int e = 6; e <= 14; e++) begin
         applyStimulus(1'b0, 1'b1);
         checkOutput("t5_pass", pass, 0);
         checkOutput("t5_fail", fail, 0);
         checkOutput("t5_busy", busy, 0);
      end
      checkOutput("t5_err", err_sticky, 0);

      // Test 6: en dropped after launch; pending attempt survives, new rise ignored
      doReset();
      for (int e = 1; e <= 15; e++) begin
         en = (e == 1);
         applyStimulus((e == 1) || (e == 3), 1'b1);
         checkOutput("t6_pass", pass, (e == 11) ? 1 : 0);
         checkOutput("t6_busy", busy, (e <= 10) ? 1 : 0);
      end
      en = 1'b1;

      // Test 7: five passing attempts, counters saturate at 3 when enabled
      doReset();
      for (int e = 1; e <= 21; e++) begin
         applyStimulus((e <= 9) && (e % 2 == 1), 1'b1);
         checkOutput("t7_pass", pass, ((e >= 11) && (e <= 19) && (e % 2 == 1)) ? 1 : 0);
`ifdef ROSE_CHK_CNT_EN
         checkOutput("t7_pcnt", pass_cnt, satCnt(e));
`else
         checkOutput("t7_pcnt", pass_cnt, 0);
`endif
         checkOutput("t7_fcnt", fail_cnt, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
